imsic_msi_rx: RTL

IMSIC_MSI_RX -- requirements
Module: imsic_msi_rx

---
 rtl/imsic_msi_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/imsic_msi_rx.sv
// MSI receive front end of an IMSIC: decodes seteipnum writes into per-file
// pending bits and presents the top pending-and-enabled identity per file.
module imsic_msi_rx #(
  parameter int          NR_SRC     = 64,
  parameter int          NR_DOMAINS = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h2400_0000,
  localparam int         IDW        = $clog2(NR_SRC)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_msi_valid,
  output logic                         o_msi_ready,
  input  logic [31:0]                  i_msi_addr,
  input  logic [31:0]                  i_msi_data,
  output logic                         o_msi_err,
  input  logic [NR_DOMAINS*NR_SRC-1:0] i_eie,
  input  logic [NR_DOMAINS-1:0]        i_delivery,
  input  logic [NR_DOMAINS-1:0]        i_claim,
  output logic [NR_DOMAINS*IDW-1:0]    o_topei,
  output logic [NR_DOMAINS-1:0]        o_Xeip_targets,
  output logic [NR_DOMAINS*NR_SRC-1:0] o_pending
);

  // Handshake: a write transfers on a rising edge where i_msi_valid and
  // o_msi_ready are both high. The requester holds valid/addr/data stable
  // until then; ready is a register that drops for one cycle after each
  // transfer so the single capture entry is always free when ready is high.

  logic                               ready_q;
  logic                               cap_valid_q;
  logic [31:0]                        cap_addr_q;
  logic [31:0]                        cap_data_q;
  logic                               accept;

  logic [NR_DOMAINS-1:0][NR_SRC-1:0]  eie;
  logic [NR_DOMAINS-1:0][NR_SRC-1:0]  pending_q;
  logic [NR_DOMAINS-1:0][NR_SRC-1:0]  pending_d;
  logic [NR_DOMAINS-1:0][IDW-1:0]     topei_q;
  logic [NR_DOMAINS-1:0][IDW-1:0]     topei_d;
  logic [NR_DOMAINS-1:0]              xeip_q;

  logic [31:0]                        off;
  logic [19:0]                        file_idx;
  logic                               is_le;
  logic                               is_be;
  logic                               file_ok;
  logic                               reg_ok;
  logic [31:0]                        id32;
  logic                               id_ok;
  logic                               set_en;

  assign accept = i_msi_valid & ready_q;
  assign eie    = i_eie;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ready_q     <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_data_q  <= '0;
    end else begin
      ready_q     <= ~accept;
      cap_valid_q <= accept;
      if (accept) begin
        cap_addr_q <= i_msi_addr;
        cap_data_q <= i_msi_data;
      end
    end
  end

  // Addresses below the base wrap to a huge file index and so fall out of range.
  assign off      = cap_addr_q - BASE_ADDR;
  assign file_idx = off[31:12];
  assign is_le    = (off[11:0] == 12'h000);
  assign is_be    = (off[11:0] == 12'h004);
  assign file_ok  = (file_idx < 20'(NR_DOMAINS));
  assign reg_ok   = file_ok & (is_le | is_be);
  assign id32     = is_be ? {cap_data_q[7:0], cap_data_q[15:8],
                             cap_data_q[23:16], cap_data_q[31:24]}
                          : cap_data_q;
  assign id_ok    = (id32 != 32'd0) && (id32 < 32'(NR_SRC));
  assign set_en   = cap_valid_q & reg_ok & id_ok;

  assign o_msi_err = cap_valid_q & ~reg_ok;

  // Claim clears first, the MSI set is applied after so it wins on a collision.
  always_comb begin
    pending_d = pending_q;
    for (int d = 0; d < NR_DOMAINS; d++) begin
      if (i_claim[d] && (topei_q[d] != '0)) begin
        pending_d[d][topei_q[d]] = 1'b0;
      end
    end
    for (int d = 0; d < NR_DOMAINS; d++) begin
      if (set_en && (file_idx == 20'(d))) begin
        pending_d[d][id32[IDW-1:0]] = 1'b1;
      end
    end
  end

  // Scan downward so the last hit is the lowest identity; bit 0 never counts.
  always_comb begin
    topei_d = '0;
    for (int d = 0; d < NR_DOMAINS; d++) begin
      for (int i = NR_SRC - 1; i >= 1; i--) begin
        if (pending_q[d][i] & eie[d][i]) begin
          topei_d[d] = IDW'(i);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= '0;
      topei_q   <= '0;
      xeip_q    <= '0;
    end else begin
      pending_q <= pending_d;
      topei_q   <= topei_d;
      for (int d = 0; d < NR_DOMAINS; d++) begin
        xeip_q[d] <= i_delivery[d] & (topei_q[d] != '0);
      end
    end
  end

  assign o_msi_ready    = ready_q;
  assign o_topei        = topei_q;
  assign o_Xeip_targets = xeip_q;
  assign o_pending      = pending_q;

endmodule
